// File: rtl/cpumc_arb_if.sv
// Shared cpumc bus bundle: CPU, HCI and DMA requester inputs plus the arbitrated outputs.
// The arbiter connects through the slave modport; the requesters drive the master side.
interface cpumc_arb_if;
  logic [15:0] cpu_a_in;
  logic        cpu_r_nw_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_rdy_out;

  logic        hci_req_in;
  logic        hci_gnt_out;
  logic [15:0] hci_a_in;
  logic        hci_r_nw_in;
  logic [7:0]  hci_d_in;

  logic        dma_req_in;
  logic        dma_gnt_out;
  logic [15:0] dma_a_in;
  logic        dma_r_nw_in;
  logic [7:0]  dma_d_in;

  logic [15:0] mc_a_out;
  logic        mc_r_nw_out;
  logic [7:0]  mc_d_out;
  logic [1:0]  owner_out;

  modport slave (
    input  cpu_a_in, cpu_r_nw_in, cpu_d_in,
    input  hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    input  dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
    output cpu_rdy_out, hci_gnt_out, dma_gnt_out,
    output mc_a_out, mc_r_nw_out, mc_d_out, owner_out
  );

  modport master (
    output cpu_a_in, cpu_r_nw_in, cpu_d_in,
    output hci_req_in, hci_a_in, hci_r_nw_in, hci_d_in,
    output dma_req_in, dma_a_in, dma_r_nw_in, dma_d_in,
    input  cpu_rdy_out, hci_gnt_out, dma_gnt_out,
    input  mc_a_out, mc_r_nw_out, mc_d_out, owner_out
  );
endinterface

// File: rtl/cpumc_arb.sv
// Fixed-priority (HCI > DMA > CPU) owner arbiter for the shared cpumc bus, with idle
// turnaround cycles on every ownership change and a bounded DMA burst length.
module cpumc_arb #(
  parameter int TURN_CYCLES   = 1,
  parameter int DMA_MAX_BURST = 256
) (
  input  logic        clk_in,
  input  logic        rst_in,
  cpumc_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_HCI  = 2'd1,
    ST_DMA  = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES - 1);
  localparam logic [8:0] BURST_LAST = 9'(DMA_MAX_BURST - 1);

  state_t      state, state_next;
  state_t      target, target_next;
  logic [3:0]  turn_cnt, turn_cnt_next;
  logic [8:0]  burst_cnt, burst_cnt_next;
  logic [15:0] hold_addr;
  logic        hci_gnt, dma_gnt;

  logic [15:0] mc_a;
  logic        mc_r_nw;
  logic [7:0]  mc_d;

  always_comb begin
    state_next     = state;
    target_next    = target;
    turn_cnt_next  = turn_cnt;
    burst_cnt_next = burst_cnt;
    unique case (state)
      ST_CPU: begin
        if (bus.hci_req_in) begin
          state_next    = ST_TURN;
          target_next   = ST_HCI;
          turn_cnt_next = 4'd0;
        end else if (bus.dma_req_in) begin
          state_next    = ST_TURN;
          target_next   = ST_DMA;
          turn_cnt_next = 4'd0;
        end
      end
      ST_TURN: begin
        if (turn_cnt == TURN_LAST) begin
          turn_cnt_next = 4'd0;
          // A target whose request vanished during turnaround falls straight back to the CPU.
          if (target == ST_HCI && bus.hci_req_in) begin
            state_next = ST_HCI;
          end else if (target == ST_DMA && bus.dma_req_in) begin
            state_next     = ST_DMA;
            burst_cnt_next = 9'd0;
          end else begin
            state_next = ST_CPU;
          end
        end else begin
          turn_cnt_next = turn_cnt + 4'd1;
        end
      end
      ST_HCI: begin
        if (!bus.hci_req_in) begin
          state_next    = ST_TURN;
          target_next   = bus.dma_req_in ? ST_DMA : ST_CPU;
          turn_cnt_next = 4'd0;
        end
      end
      ST_DMA: begin
        if (!bus.dma_req_in) begin
          state_next    = ST_TURN;
          target_next   = bus.hci_req_in ? ST_HCI : ST_CPU;
          turn_cnt_next = 4'd0;
        end else if (burst_cnt == BURST_LAST) begin
          if (bus.hci_req_in) begin
            state_next    = ST_TURN;
            target_next   = ST_HCI;
            turn_cnt_next = 4'd0;
          end else begin
            burst_cnt_next = 9'd0;
          end
        end else begin
          burst_cnt_next = burst_cnt + 9'd1;
        end
      end
      default: state_next = ST_CPU;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_CPU;
      target    <= ST_CPU;
      turn_cnt  <= 4'd0;
      burst_cnt <= 9'd0;
      hold_addr <= 16'h0000;
      hci_gnt   <= 1'b0;
      dma_gnt   <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      turn_cnt  <= turn_cnt_next;
      burst_cnt <= burst_cnt_next;
      hci_gnt   <= (state_next == ST_HCI);
      dma_gnt   <= (state_next == ST_DMA);
      // Freeze the address seen just before turnaround so the bus stays quiet during it.
      if (state != ST_TURN) hold_addr <= mc_a;
    end
  end

  always_comb begin
    mc_a    = bus.cpu_a_in;
    mc_r_nw = bus.cpu_r_nw_in;
    mc_d    = bus.cpu_d_in;
    unique case (state)
      ST_CPU: begin
        mc_a    = bus.cpu_a_in;
        mc_r_nw = bus.cpu_r_nw_in;
        mc_d    = bus.cpu_d_in;
      end
      ST_HCI: begin
        mc_a    = bus.hci_a_in;
        mc_r_nw = bus.hci_r_nw_in;
        mc_d    = bus.hci_d_in;
      end
      ST_DMA: begin
        mc_a    = bus.dma_a_in;
        mc_r_nw = bus.dma_r_nw_in;
        mc_d    = bus.dma_d_in;
      end
      ST_TURN: begin
        mc_a    = hold_addr;
        mc_r_nw = 1'b1;
        mc_d    = 8'h00;
      end
      default: ;
    endcase
  end

  assign bus.mc_a_out    = mc_a;
  assign bus.mc_r_nw_out = mc_r_nw;
  assign bus.mc_d_out    = mc_d;
  assign bus.owner_out   = state;
  assign bus.hci_gnt_out = hci_gnt;
  assign bus.dma_gnt_out = dma_gnt;
  assign bus.cpu_rdy_out = (state == ST_CPU) && !bus.hci_req_in && !bus.dma_req_in;

endmodule

// File: tb/tb_cpumc_arb.sv
// Self-checking bench for cpumc_arb: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a cycle-count ownership model.
module tb_cpumc_arb;
  localparam int TURN_CYCLES   = 1;
  localparam int DMA_MAX_BURST = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  cpumc_arb_if bus();

  cpumc_arb #(.TURN_CYCLES(TURN_CYCLES), .DMA_MAX_BURST(DMA_MAX_BURST)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  typedef struct packed {
    logic       rst;
    logic       hci;
    logic       dma;
    logic [1:0] owner;
    logic       hci_gnt;
    logic       dma_gnt;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // Ownership model: 0=CPU 1=HCI 2=DMA 3=turnaround; turn_left counts down, run counts DMA cycles.
  int          m_owner = 0;
  int          m_target = 0;
  int          m_turn_left = 0;
  int          m_run = 0;
  logic [15:0] m_hold = 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beginTurn(input int t);
    m_owner     = 3;
    m_target    = t;
    m_turn_left = TURN_CYCLES;
  endtask

  task automatic modelStep(input logic r, input logic h, input logic d, input logic [15:0] a_now);
    if (r) begin
      m_owner = 0; m_target = 0; m_turn_left = 0; m_run = 0; m_hold = 16'h0000;
    end else begin
      if (m_owner != 3) m_hold = a_now;
      case (m_owner)
        0: if (h) beginTurn(1); else if (d) beginTurn(2);
        1: if (!h) beginTurn(d ? 2 : 0);
        2: begin
          m_run++;
          if (!d) beginTurn(h ? 1 : 0);
          else if ((m_run % DMA_MAX_BURST) == 0 && h) beginTurn(1);
        end
        default: begin
          m_turn_left--;
          if (m_turn_left == 0) begin
            if (m_target == 1 && h) m_owner = 1;
            else if (m_target == 2 && d) begin m_owner = 2; m_run = 0; end
            else m_owner = 0;
          end
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic d,
                               input logic [15:0] ca, input bit chk);
    logic [15:0] e_a;
    logic        e_rnw;
    logic [7:0]  e_d;
    @(negedge clk_in);
    rst_in             = r;
    bus.hci_req_in     = h;
    bus.dma_req_in     = d;
    bus.cpu_a_in       = ca;
    bus.cpu_r_nw_in    = 1'($urandom);
    bus.cpu_d_in       = 8'($urandom);
    bus.hci_a_in       = 16'($urandom);
    bus.hci_r_nw_in    = 1'($urandom);
    bus.hci_d_in       = 8'($urandom);
    bus.dma_a_in       = 16'($urandom);
    bus.dma_r_nw_in    = 1'($urandom);
    bus.dma_d_in       = 8'($urandom);
    #1;
    case (m_owner)
      0: begin e_a = bus.cpu_a_in; e_rnw = bus.cpu_r_nw_in; e_d = bus.cpu_d_in; end
      1: begin e_a = bus.hci_a_in; e_rnw = bus.hci_r_nw_in; e_d = bus.hci_d_in; end
      2: begin e_a = bus.dma_a_in; e_rnw = bus.dma_r_nw_in; e_d = bus.dma_d_in; end
      default: begin e_a = m_hold; e_rnw = 1'b1; e_d = 8'h00; end
    endcase
    if (chk) begin
      checkOutput("owner", {30'b0, bus.owner_out}, 32'(m_owner));
      checkOutput("grants", {30'b0, bus.hci_gnt_out, bus.dma_gnt_out},
                  {30'b0, m_owner == 1, m_owner == 2});
      checkOutput("cpu_rdy", {31'b0, bus.cpu_rdy_out}, {31'b0, (m_owner == 0) && !h && !d});
      checkOutput("mc_bus", {7'b0, bus.mc_a_out, bus.mc_r_nw_out, bus.mc_d_out},
                  {7'b0, e_a, e_rnw, e_d});
    end
    modelStep(r, h, d, e_a);
  endtask

  task automatic addVec(input logic r, input logic h, input logic d, input logic [1:0] o,
                        input logic hg, input logic dg, input logic rdy);
    vec_t v;
    v.rst = r; v.hci = h; v.dma = d; v.owner = o;
    v.hci_gnt = hg; v.dma_gnt = dg; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    logic [15:0] ca;
    logic        h, d;

    // HCI take/release (rows 0-6), simultaneous requests (7-15), abandoned DMA (16-18),
    // reset mid-DMA (19-23), burst yield and regrant (24-41), burst wrap (42-55).
    addVec(0,0,0, 2'd0,0,0,1); addVec(0,1,0, 2'd0,0,0,0); addVec(0,1,0, 2'd3,0,0,0);
    addVec(0,1,0, 2'd1,1,0,0); addVec(0,0,0, 2'd1,1,0,0); addVec(0,0,0, 2'd3,0,0,0);
    addVec(0,0,0, 2'd0,0,0,1);
    addVec(0,1,1, 2'd0,0,0,0); addVec(0,1,1, 2'd3,0,0,0); addVec(0,1,1, 2'd1,1,0,0);
    addVec(0,0,1, 2'd1,1,0,0); addVec(0,0,1, 2'd3,0,0,0); addVec(0,0,1, 2'd2,0,1,0);
    addVec(0,0,0, 2'd2,0,1,0); addVec(0,0,0, 2'd3,0,0,0); addVec(0,0,0, 2'd0,0,0,1);
    addVec(0,0,1, 2'd0,0,0,0); addVec(0,0,0, 2'd3,0,0,0); addVec(0,0,0, 2'd0,0,0,1);
    addVec(0,0,1, 2'd0,0,0,0); addVec(0,0,1, 2'd3,0,0,0); addVec(0,0,1, 2'd2,0,1,0);
    addVec(1,0,1, 2'd2,0,1,0); addVec(0,0,0, 2'd0,0,0,1);
    addVec(0,0,1, 2'd0,0,0,0); addVec(0,0,1, 2'd3,0,0,0); addVec(0,0,1, 2'd2,0,1,0);
    addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd2,0,1,0);
    addVec(0,1,1, 2'd3,0,0,0); addVec(0,1,1, 2'd1,1,0,0); addVec(0,0,1, 2'd1,1,0,0);
    addVec(0,0,1, 2'd3,0,0,0); addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd2,0,1,0);
    addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd3,0,0,0);
    addVec(0,0,0, 2'd1,1,0,0); addVec(0,0,0, 2'd3,0,0,0); addVec(0,0,0, 2'd0,0,0,1);
    addVec(0,0,1, 2'd0,0,0,0); addVec(0,0,1, 2'd3,0,0,0);
    for (int i = 0; i < 6; i++) addVec(0,0,1, 2'd2,0,1,0);
    addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd2,0,1,0); addVec(0,1,1, 2'd3,0,0,0);
    addVec(0,0,0, 2'd1,1,0,0); addVec(0,0,0, 2'd3,0,0,0); addVec(0,0,0, 2'd0,0,0,1);

    rst_in = 1'b1;
    bus.hci_req_in = 1'b0;
    bus.dma_req_in = 1'b0;
    applyStimulus(1, 0, 0, 16'($urandom), 0);
    applyStimulus(1, 0, 0, 16'($urandom), 1);

    for (int i = 0; i < 100; i++) begin
      ca = 16'($urandom);
      applyStimulus(0, 0, 0, ca, 1);
      checkOutput("idle_addr", {16'b0, bus.mc_a_out}, {16'b0, ca});
      checkOutput("idle_state", {28'b0, bus.owner_out, bus.cpu_rdy_out, bus.hci_gnt_out | bus.dma_gnt_out},
                  {28'b0, 2'd0, 1'b1, 1'b0});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v.rst, v.hci, v.dma, 16'($urandom), 1);
      checkOutput($sformatf("vec%0d", i),
                  {27'b0, bus.owner_out, bus.hci_gnt_out, bus.dma_gnt_out, bus.cpu_rdy_out},
                  {27'b0, v.owner, v.hci_gnt, v.dma_gnt, v.rdy});
    end

    // Turnaround must replay the last CPU address and present a quiet read.
    applyStimulus(0, 0, 1, 16'hBEEF, 1);
    applyStimulus(0, 0, 0, 16'h1234, 1);
    checkOutput("turn_bus", {6'b0, bus.owner_out, bus.mc_a_out, bus.mc_r_nw_out, bus.mc_d_out},
                {6'b0, 2'd3, 16'hBEEF, 1'b1, 8'h00});
    applyStimulus(0, 0, 0, 16'h5678, 1);
    checkOutput("abandon_cpu", {29'b0, bus.owner_out, bus.dma_gnt_out}, {29'b0, 2'd0, 1'b0});

    // Reset during HCI ownership returns to the CPU without a turnaround cycle.
    applyStimulus(0, 1, 0, 16'($urandom), 1);
    applyStimulus(0, 1, 0, 16'($urandom), 1);
    applyStimulus(1, 1, 0, 16'($urandom), 1);
    checkOutput("rst_hci_pre", {31'b0, bus.hci_gnt_out}, 32'd1);
    applyStimulus(0, 0, 0, 16'($urandom), 1);
    checkOutput("rst_hci_post", {29'b0, bus.owner_out, bus.hci_gnt_out}, {29'b0, 2'd0, 1'b0});

    h = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) h = ~h;
      if ($urandom_range(0, 99) < 20) d = ~d;
      applyStimulus($urandom_range(0, 199) == 0, h, d, 16'($urandom), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpumc_arb.md
CPUMC_ARB -- requirements
Module: cpumc_arb

Interface
REQ-001 Parameter TURN_CYCLES, default 1: number of idle bus cycles inserted on every ownership change; legal range 1..15.
REQ-002 Parameter DMA_MAX_BURST, default 256: maximum consecutive DMA-owned cycles before the DMA owner yields to a pending HCI request; legal range 1..256.
REQ-003 Ports (name  direction  width  meaning):
- clk_in  in  1  system clock; the only clock; all state changes on its rising edge.
- rst_in  in  1  synchronous reset, active-high.
- cpu_a_in  in  16  rp2a03 address.
- cpu_r_nw_in  in  1  rp2a03 read/not-write.
- cpu_d_in  in  8  rp2a03 write data.
- cpu_rdy_out  out  1  rp2a03 ready; low stalls the CPU.
- hci_req_in  in  1  debug host requests the bus (level).
- hci_gnt_out  out  1  HCI owns the bus.
- hci_a_in  in  16  HCI address.
- hci_r_nw_in  in  1  HCI read/not-write.
- hci_d_in  in  8  HCI write data.
- dma_req_in  in  1  DMA engine requests the bus (level).
- dma_gnt_out  out  1  DMA owns the bus.
- dma_a_in  in  16  DMA address.
- dma_r_nw_in  in  1  DMA read/not-write.
- dma_d_in  in  8  DMA write data.
- mc_a_out  out  16  shared cpumc address.
- mc_r_nw_out  out  1  shared cpumc read/not-write.
- mc_d_out  out  8  shared cpumc write data.
- owner_out  out  2  current owner: 0=CPU, 1=HCI, 2=DMA, 3=turnaround.

Function
REQ-004 The FSM SHALL have exactly four states: CPU, TURN, HCI, DMA; owner_out SHALL equal the state encoding (CPU=0, HCI=1, DMA=2, TURN=3).
REQ-005 Fixed priority SHALL be HCI > DMA > CPU; the CPU owns the bus whenever no request is pending.
REQ-006 In CPU: hci_req_in=1 -> TURN (target HCI); else dma_req_in=1 -> TURN (target DMA); else stay in CPU.
REQ-007 In TURN: a 4-bit counter SHALL count TURN_CYCLES cycles, then the FSM enters the latched target; if the target is HCI/DMA and its request is low on that final cycle, the FSM SHALL go directly to CPU with no additional turnaround.
REQ-008 In HCI: stay while hci_req_in=1; on drop -> TURN (target DMA if dma_req_in=1, else CPU).
REQ-009 In DMA: a 9-bit burst counter SHALL clear on entry and increment each DMA cycle.
- On dma_req_in drop -> TURN (target HCI if hci_req_in=1, else CPU).
- When the counter reaches DMA_MAX_BURST-1 with hci_req_in=1 -> TURN (target HCI), even though dma_req_in is high.
- When the counter reaches DMA_MAX_BURST-1 with hci_req_in=0 -> the counter SHALL wrap to 0 and the FSM stays in DMA.
REQ-010 hci_gnt_out and dma_gnt_out SHALL be registered, high exactly while the state is HCI or DMA respectively, and never high simultaneously.
REQ-011 Bus mux (combinational from state):
- CPU -> cpu_* inputs.
- HCI -> hci_* inputs.
- DMA -> dma_* inputs.
- TURN -> mc_r_nw_out=1, mc_d_out=8'h00, mc_a_out holding the last address driven before TURN.
REQ-012 cpu_rdy_out SHALL be 1 only when state=CPU and hci_req_in=0 and dma_req_in=0 (combinational), so the CPU stalls in the cycle a request appears.
REQ-013 A requester SHALL drive its bus inputs valid for every cycle its grant is high; the arbiter performs no buffering of requester data.
REQ-014 A request dropped and raised in the same cycle as a state decision SHALL be evaluated using the input level sampled on that clock edge; no request is queued.

Reset
REQ-015 With rst_in=1 at a clock edge, the next state SHALL be as follows, regardless of the current state:
- state=CPU, both grants=0, TURN and burst counters=0, held address=16'h0000.
- cpu_rdy_out=1 (if no request is pending), owner_out=0.
REQ-016 Reset asserted mid-HCI or mid-DMA SHALL drop the grant on the next edge without passing through TURN.

Verification
REQ-017 Idle: no requests for 100 cycles -> owner_out=0, cpu_rdy_out=1, mc_a_out tracks cpu_a_in, both grants=0.
REQ-018 HCI take/release with TURN_CYCLES=1: hci_req_in rises at cycle N -> cpu_rdy_out=0 at N; owner=3 at N+1; hci_gnt_out=1 at N+2. hci_req_in falls at M -> owner=3 at M+1; owner=0 and cpu_rdy_out=1 at M+2.
REQ-019 Simultaneous hci_req_in and dma_req_in rise in CPU -> HCI granted first. After HCI releases -> TURN -> dma_gnt_out=1; no cycle with both grants high.
REQ-020 Burst yield with DMA_MAX_BURST=4: dma_req_in held high, hci_req_in raised at DMA cycle 1 -> dma_gnt_out high exactly 4 cycles, then TURN, then hci_gnt_out=1. After HCI releases -> DMA is regranted with the burst counter cleared.
REQ-021 Abandoned request: dma_req_in pulses for 1 cycle -> TURN -> owner=0 directly, with dma_gnt_out never asserted. During TURN: mc_r_nw_out=1, mc_d_out=8'h00, mc_a_out=last cpu_a_in.
REQ-022 Reset mid-DMA: rst_in=1 for 1 cycle while dma_gnt_out=1 -> next cycle dma_gnt_out=0, owner_out=0, burst counter=0.
